// File: rtl/usb_rx_pkg.sv
// Shared types and constants for the USB receive path.
package usb_rx_pkg;
  localparam int RX_BYTE_W = 8;
  localparam int STUFF_RUN = 6;

  typedef logic [RX_BYTE_W-1:0] rx_byte_t;
endpackage

// File: rtl/rx_fifo.sv
// DEPTH x 8 synchronous FIFO with extra-MSB pointers to tell full from empty.
module rx_fifo
  import usb_rx_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic     clk,
  input  logic     n_rst,
  input  logic     push,
  input  rx_byte_t push_data,
  input  logic     pop,
  output rx_byte_t head,
  output logic     full,
  output logic     empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  rx_byte_t    mem [DEPTH];
  logic        do_push;
  logic        do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop & ~empty;
  // A pop at full frees the slot the push is about to overwrite.
  assign do_push = push & (~full | do_pop);
  assign head    = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // NOTE: sequential state uses <= so every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage has no reset; head is forced to zero while empty, so stale entries never reach the output.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end
endmodule

// File: rtl/rx_byte_assembler.sv
// USB RX byte assembler: destuffs the decoded bit stream, packs bytes LSB-first
// and queues them toward the packet decoder with sticky error reporting.
module rx_byte_assembler
  import usb_rx_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic     clk,
  input  logic     n_rst,
  input  logic     rcving,
  input  logic     shift_enable,
  input  logic     d_orig,
  input  logic     eop,
  output logic     shift_stop,
  output rx_byte_t rx_data,
  output logic     rx_valid,
  input  logic     rx_ready,
  output logic     stuff_err,
  output logic     overflow,
  output logic     partial_err,
  output logic     packet_done
);
  logic [2:0] bit_cnt;
  logic [2:0] ones_cnt;
  rx_byte_t   sreg;
  logic       rcving_q;

  logic       stuff_slot;
  logic       bit_strobe;
  logic       data_bit;
  logic       byte_push;
  logic       stuff_bad;
  logic       partial_set;
  logic       ovf_set;
  logic       flag_clr;
  logic       fifo_pop;
  logic       fifo_full;
  logic       fifo_empty;
  rx_byte_t   byte_next;

  // NOTE: every combinational output gets a default first, so no path leaves one unassigned and infers a latch.
  always_comb begin
    stuff_slot  = (ones_cnt == 3'(STUFF_RUN));
    bit_strobe  = rcving & shift_enable & ~eop;
    data_bit    = 1'b0;
    stuff_bad   = 1'b0;
    if (bit_strobe) begin
      data_bit  = ~stuff_slot;
      stuff_bad = stuff_slot & d_orig;
    end
    byte_next   = {d_orig, sreg[RX_BYTE_W-1:1]};
    byte_push   = data_bit & (bit_cnt == 3'd7);
    partial_set = rcving & eop & (bit_cnt != 3'd0);
    ovf_set     = byte_push & fifo_full & ~rx_ready;
    flag_clr    = rcving & ~rcving_q;
  end

  assign shift_stop = rcving & stuff_slot;
  assign rx_valid   = ~fifo_empty;
  assign fifo_pop   = rx_valid & rx_ready;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      bit_cnt     <= '0;
      ones_cnt    <= '0;
      sreg        <= '0;
      rcving_q    <= 1'b0;
      packet_done <= 1'b0;
      stuff_err   <= 1'b0;
      overflow    <= 1'b0;
      partial_err <= 1'b0;
    end else begin
      rcving_q    <= rcving;
      packet_done <= rcving & eop;
      // A flag raised in the same cycle as the rcving rise survives the clear.
      stuff_err   <= (stuff_err   & ~flag_clr) | stuff_bad;
      overflow    <= (overflow    & ~flag_clr) | ovf_set;
      partial_err <= (partial_err & ~flag_clr) | partial_set;

      if (!rcving || eop) begin
        bit_cnt  <= '0;
        ones_cnt <= '0;
        sreg     <= '0;
      end else if (shift_enable) begin
        if (stuff_slot) begin
          ones_cnt <= '0;
        end else begin
          sreg     <= byte_next;
          bit_cnt  <= bit_cnt + 3'd1;
          ones_cnt <= d_orig ? ones_cnt + 3'd1 : 3'd0;
        end
      end
    end
  end

  rx_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .n_rst     (n_rst),
    .push      (byte_push),
    .push_data (byte_next),
    .pop       (fifo_pop),
    .head      (rx_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );
endmodule

// File: doc/rx_byte_assembler.md
# rx_byte_assembler

Receive-side byte assembler for the USB RX path. It sits directly downstream of the RX bit timer and consumes that timer's one-cycle `shift_enable` strobe together with the NRZI-decoded line bit. It removes stuffed bits, returning `shift_stop` to the timer so stuffed bits are not counted. It packs data bits LSB-first into bytes and queues them in a small FIFO with a valid/ready interface toward the packet decoder.

## Interface
- `DEPTH`, 8: FIFO entries; power of two, ≥2.
- `clk` input 1: system clock; all state updates on rising edge.
- `n_rst` input 1: asynchronous, active-low reset.
- `rcving` input 1: high while a packet is being received.
- `shift_enable` input 1: one-cycle strobe; sample `d_orig` this cycle.
- `d_orig` input 1: NRZI-decoded data bit.
- `eop` input 1: one-cycle end-of-packet pulse.
- `shift_stop` output 1: combinational; high while the next sampled bit is a stuff bit.
- `rx_data` output 8: FIFO head byte.
- `rx_valid` output 1: FIFO non-empty.
- `rx_ready` input 1: consumer pops head when `rx_valid & rx_ready`.
- `stuff_err` output 1: sticky; a 1 was received where a stuff 0 was required.
- `overflow` output 1: sticky; a byte was dropped because the FIFO was full.
- `partial_err` output 1: sticky; `eop` arrived with 1–7 bits pending.
- `packet_done` output 1: one-cycle pulse after `eop` is processed.

## Operation
- Reset: all counters, the shift register and the FIFO pointers are 0. All outputs are low, including `rx_data` = 0x00.
- `ones_cnt` (3 bits) counts consecutive data 1s.
- `shift_stop = rcving & (ones_cnt == 6)`.
- On `shift_enable` with `ones_cnt == 6` (stuff slot):
  - bit 0: discarded; `ones_cnt` ← 0.
  - bit 1: `stuff_err` ← 1; bit discarded; `ones_cnt` ← 0.
- On `shift_enable` otherwise (data bit):
  - `sreg` ← {d_orig, sreg[7:1]}.
  - `bit_cnt` ← bit_cnt + 1 (3-bit, wraps).
  - `ones_cnt` ← d_orig ? ones_cnt + 1 : 0.
- On the 8th data bit (`bit_cnt == 7` before increment), the assembled byte {d_orig, sreg[7:1]} is pushed the same edge. If the FIFO is full and no pop occurs this cycle, the byte is dropped and `overflow` ← 1.
- On `eop` while `rcving`:
  - if `bit_cnt != 0`, `partial_err` ← 1 and the pending bits are discarded.
  - `bit_cnt`, `ones_cnt` and `sreg` ← 0.
  - `packet_done` pulses the next cycle.
  - If `eop` and `shift_enable` are asserted together, `eop` wins and the bit is ignored.
- While `rcving` is low, `bit_cnt`, `ones_cnt` and `sreg` are held at 0 and `shift_enable` is ignored. FIFO contents are retained.
- A rising edge of `rcving` (registered compare) clears `stuff_err`, `overflow` and `partial_err`. FIFO contents are not cleared.
- Every byte is queued, including SYNC and PID; framing is the consumer's job.

## Timing
- Byte latency: push at edge E, which ends the cycle where the 8th data `shift_enable` is high. `rx_valid` is high and `rx_data` valid from cycle E+1.
- Pop at edge where `rx_valid & rx_ready`. The next entry or `rx_valid` = 0 is visible the following cycle.
- Full FIFO with simultaneous push and pop: both occur and no overflow.
- Empty FIFO: a push cannot be popped in the same cycle.
- Sticky flags assert one cycle after the causing strobe.
- `shift_stop` has zero latency. It rises in the cycle after the 6th consecutive 1 is accepted.
- Reset mid-packet: all state is lost immediately, with no `packet_done` pulse.

## Structure
- Shared package `usb_rx_pkg`:
  - `RX_BYTE_W` = 8
  - `STUFF_RUN` = 6
  - `typedef logic [7:0] rx_byte_t`
- One sub-module `rx_fifo`: parameterised DEPTH × 8 synchronous FIFO with push/pop, full/empty, `$clog2(DEPTH)+1`-bit pointers and async active-low reset.
- Bit, stuff and error logic stay in the top module.

## Test plan
- Send 0xA5 then 0x3C LSB-first, one bit per 8-cycle `shift_enable`, then `eop` → `rx_data` = 0xA5 then 0x3C, one `packet_done`, no errors.
- Send 0xFF with a stuff 0 after the 6th 1 → `shift_stop` high during the stuff slot, byte 0xFF queued, no `stuff_err`.
- Send seven consecutive 1s without a stuff 0 → `stuff_err` = 1, cleared on the next `rcving` rise.
- Hold `rx_ready` = 0 and push DEPTH+1 bytes → first DEPTH bytes intact, `overflow` = 1. Then push and pop in the same cycle at full → no additional drop.
- Send `eop` after 3 bits of a byte → `partial_err` = 1, nothing queued, `packet_done` pulses once.
- Deassert `n_rst` mid-byte → outputs go to 0 immediately; a new packet after reset assembles correctly.
